// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; predicts in IF, resolves and trains in EX.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic [31:0] PCE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MissCnt
);
    localparam int N = 1 << INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;
    localparam logic [2:0] NOBRANCH = 3'd0;

    logic            valid  [N];
    logic [TW-1:0]   tag    [N];
    logic [31:0]     target [N];
    logic [1:0]      ctr    [N];

    logic [INDEX_BITS-1:0] fidx, eidx;
    logic hit_f, hit_e, is_br, upd;
    logic unused_pcf;

    assign unused_pcf  = ^PCF[1:0];
    assign fidx        = PCF[INDEX_BITS+1:2];
    assign eidx        = PCE[INDEX_BITS+1:2];
    assign hit_f       = valid[fidx] && tag[fidx] == PCF[31:INDEX_BITS+2];
    assign hit_e       = valid[eidx] && tag[eidx] == PCE[31:INDEX_BITS+2];
    assign PredTakenF  = hit_f && ctr[fidx][1];
    assign PredTargetF = PredTakenF ? target[fidx] : 32'd0;
    assign is_br       = BranchTypeE != NOBRANCH;
    assign upd         = ValidE && is_br;
    // Non-branches predicted taken are stale/aliased hits and must redirect too.
    assign MispredictE = ValidE && (is_br ? (BranchE != PredTakenE || (BranchE && PredTakenE && PredTargetE != BranchTargetE))
                                          : PredTakenE);
    assign CorrectPCE  = (is_br && BranchE) ? BranchTargetE : PCE + 32'd4;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            for (int i = 0; i < N; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= '0;
            end
            BranchCnt <= '0;
            MissCnt   <= '0;
        end else begin
            if (upd) begin
                BranchCnt <= BranchCnt + 32'd1;
                if (hit_e && BranchE) begin
                    ctr[eidx]    <= (ctr[eidx] == 2'd3) ? 2'd3 : ctr[eidx] + 2'd1;
                    target[eidx] <= BranchTargetE;
                end else if (hit_e) begin
                    ctr[eidx] <= (ctr[eidx] == 2'd0) ? 2'd0 : ctr[eidx] - 2'd1;
                end else if (BranchE) begin
                    valid[eidx]  <= 1'b1;
                    tag[eidx]    <= PCE[31:INDEX_BITS+2];
                    target[eidx] <= BranchTargetE;
                    ctr[eidx]    <= 2'b10;
                end
            end
            if (MispredictE)
                MissCnt <= MissCnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random stimulus, expected responses queued from a PC-level reference model.
module tb_branch_predictor;
    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b1;
    logic [31:0] PCF = '0, PCE = '0, BranchTargetE = '0, PredTargetE = '0;
    logic        ValidE = 1'b0, BranchE = 1'b0, PredTakenE = 1'b0;
    logic [2:0]  BranchTypeE = '0;
    logic        PredTakenF, MispredictE;
    logic [31:0] PredTargetF, CorrectPCE, BranchCnt, MissCnt;

    branch_predictor dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ValidE(ValidE), .PCE(PCE), .BranchTypeE(BranchTypeE), .BranchE(BranchE), .BranchTargetE(BranchTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE), .CorrectPCE(CorrectPCE),
        .BranchCnt(BranchCnt), .MissCnt(MissCnt)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    typedef struct { logic pt; logic [31:0] ptg; logic mp; logic [31:0] cpc; logic [31:0] bc; logic [31:0] mc; } exp_t;
    typedef struct { bit v; bit [31:0] pc; bit [31:0] tgt; int ctr; } ent_t;

    exp_t      q[$];
    ent_t      m[16];
    bit [31:0] bcnt = 0, mcnt = 0;
    int        checks = 0, errors = 0;
    bit        done = 0;

    // The entry a PC maps to belongs to it only if it was allocated by the same word address.
    function automatic bit owns(bit [31:0] pc);
        return m[pc[5:2]].v && (m[pc[5:2]].pc >> 2) == (pc >> 2);
    endfunction

    function automatic bit pred(bit [31:0] pc);
        return owns(pc) && m[pc[5:2]].ctr >= 2;
    endfunction

    task automatic step(bit rst, bit [31:0] pcf, bit ve, bit [31:0] pce, bit [2:0] bt, bit br,
                        bit [31:0] bte, bit pte, bit [31:0] ptge);
        exp_t e;
        bit   isbr;
        @(posedge CPU_CLK);
        #1;
        CPU_RST = rst; PCF = pcf; ValidE = ve; PCE = pce; BranchTypeE = bt; BranchE = br;
        BranchTargetE = bte; PredTakenE = pte; PredTargetE = ptge;
        isbr  = bt != 3'd0;
        e.pt  = pred(pcf);
        e.ptg = e.pt ? m[pcf[5:2]].tgt : 32'd0;
        e.mp  = ve && (isbr ? (br != pte || (br && pte && ptge != bte)) : pte);
        e.cpc = (isbr && br) ? bte : pce + 32'd4;
        e.bc  = bcnt;
        e.mc  = mcnt;
        q.push_back(e);
        if (rst) begin
            foreach (m[i]) m[i] = '{0, 0, 0, 0};
            bcnt = 0;
            mcnt = 0;
        end else if (ve) begin
            if (isbr) begin
                bcnt++;
                if (owns(pce)) begin
                    m[pce[5:2]].ctr = br ? (m[pce[5:2]].ctr < 3 ? m[pce[5:2]].ctr + 1 : 3)
                                         : (m[pce[5:2]].ctr > 0 ? m[pce[5:2]].ctr - 1 : 0);
                    if (br) m[pce[5:2]].tgt = bte;
                end else if (br) begin
                    m[pce[5:2]] = '{1, pce, bte, 2};
                end
            end
            if (e.mp) mcnt++;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CPU_CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, e.pt});
            chk("PredTargetF", PredTargetF, e.ptg);
            chk("MispredictE", {31'd0, MispredictE}, {31'd0, e.mp});
            if (e.mp) chk("CorrectPCE", CorrectPCE, e.cpc);
            chk("BranchCnt", BranchCnt, e.bc);
            chk("MissCnt", MissCnt, e.mc);
        end
    end

    bit [31:0] pool[8] = '{32'h100, 32'h140, 32'h104, 32'h300, 32'h180, 32'h1C0, 32'h13C, 32'hFFFFFFFC};
    bit [31:0] tpool[4] = '{32'h80, 32'h200, 32'h400, 32'h84};

    initial begin
        repeat (2) @(posedge CPU_CLK);
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h100, 3'd1, 1, 32'h80, 0, 0);
        step(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h100, 1, 32'h100, 3'd1, 0, 32'h80, 1, 32'h80);
        step(0, 32'h100, 1, 32'h100, 3'd1, 0, 32'h80, 0, 0);
        step(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h100, 1, 32'h100, 3'd1, 1, 32'h80, i >= 2, i >= 2 ? 32'h80 : 0);
        step(0, 32'h100, 1, 32'h140, 3'd2, 1, 32'h200, 0, 0);
        step(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h140, 1, 32'h300, 3'd0, 0, 0, 1, 32'h500);
        step(0, 32'h140, 0, 32'h180, 3'd3, 1, 32'h400, 0, 0);
        step(0, 32'h180, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h140, 1, 32'h180, 3'd3, 1, 32'h400, 0, 0);
        step(0, 32'h140, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h180, 1, 32'hFFFFFFFC, 3'd0, 0, 0, 1, 32'h4);
        for (int i = 0; i < 3000; i++) begin
            bit [31:0] pce, ptge;
            bit        pte;
            pce = pool[$urandom_range(7)];
            if ($urandom_range(1)) begin
                pte  = pred(pce);
                ptge = pte ? m[pce[5:2]].tgt : 0;
            end else begin
                pte  = 1'($urandom_range(1));
                ptge = tpool[$urandom_range(3)];
            end
            step($urandom_range(63) == 0, pool[$urandom_range(7)], $urandom_range(7) != 0, pce,
                 $urandom_range(3) == 0 ? 3'd0 : 3'($urandom_range(6, 1)), 1'($urandom_range(1)),
                 tpool[$urandom_range(3)], pte, ptge);
        end
        @(negedge CPU_CLK);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RISC-V pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In IF it looks up the fetch PC and supplies a predicted next PC to NPC generation. In EX it consumes the branch outcome from branch decision (`BranchE`) and the resolved target, then updates the table. It flags mispredictions so the hazard unit flushes IF/ID and redirects fetch.

## Interface
- `INDEX_BITS`, 4: table has 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].
- `CPU_CLK` in 1: clock. All state updates on the rising edge.
- `CPU_RST` in 1: reset, synchronous, active-high.
- `PCF` in 32: fetch-stage PC to look up.
- `PredTakenF` out 1: predict taken for `PCF`.
- `PredTargetF` out 32: predicted target for `PCF`. It is 0 when `PredTakenF`=0.
- `ValidE` in 1: EX holds a real instruction that is neither a bubble nor stalled this cycle.
- `PCE` in 32: PC of the EX instruction.
- `BranchTypeE` in 3: branch type using the Parameters.v encodings. `NOBRANCH` means not a branch.
- `BranchE` in 1: branch taken, from branch decision.
- `BranchTargetE` in 32: resolved branch target.
- `PredTakenE` in 1: `PredTakenF` for this instruction, carried through the pipeline registers.
- `PredTargetE` in 32: `PredTargetF` for this instruction, carried through the pipeline registers.
- `MispredictE` out 1: redirect required.
- `CorrectPCE` out 32: PC to fetch on redirect.
- `BranchCnt` out 32: count of resolved branches.
- `MissCnt` out 32: count of mispredictions.

## Operation
- Entry fields: `valid`, `tag` = PC[31:INDEX_BITS+2], `target`[31:0], `ctr`[1:0].
- Lookup is combinational on `PCF`:
  - hit = `valid` && tag match.
  - `PredTakenF` = hit && `ctr`[1].
  - `PredTargetF` = `target` when `PredTakenF`=1, else 0.
- `isBr` = (`BranchTypeE` != `NOBRANCH`). A table update happens only when `ValidE` && `isBr`.
  - Hit, taken: `ctr` saturating increment (max 3); `target` <= `BranchTargetE`.
  - Hit, not taken: `ctr` saturating decrement (min 0); `target` unchanged.
  - Miss, taken: allocate and overwrite the entry: `valid`=1, tag, `target`=`BranchTargetE`, `ctr`=2'b10.
  - Miss, not taken: no write.
- `MispredictE` = `ValidE` && (A || B), where:
  - A = `isBr` && (`BranchE` != `PredTakenE` || (`BranchE` && `PredTakenE` && `PredTargetE` != `BranchTargetE`)).
  - B = !`isBr` && `PredTakenE`, covering stale or aliased predictions. B never writes the table.
- `CorrectPCE` = (`isBr` && `BranchE`) ? `BranchTargetE` : `PCE`+4. The addition is 32-bit and wraps modulo 2^32. `CorrectPCE` is valid whenever `MispredictE`=1; its value is don't-care otherwise.
- Counters:
  - `BranchCnt` increments on each `ValidE` && `isBr`.
  - `MissCnt` increments on each cycle with `MispredictE`=1, including case B.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Storage is a register array. There is no read-modify-write hazard beyond the single EX write per cycle.

## Timing
- Lookup (`PredTakenF`/`PredTargetF`) and resolution (`MispredictE`/`CorrectPCE`) are combinational, with zero latency.
- Table and counter writes occur at the rising edge. A lookup sees them from the next cycle.
- Same-cycle lookup and update of the same index: the lookup returns pre-update contents (no bypass).
- `ValidE`=0: no table write, no counter change, `MispredictE`=0. Stalled instructions must present `ValidE`=0 to avoid double updates.
- Reset, at any cycle including mid-update, takes priority over any update in that cycle:
  - all `valid` <= 0, `ctr` <= 0, `target` <= 0, `tag` <= 0;
  - `BranchCnt` = `MissCnt` = 0.
  - First cycle after reset: `PredTakenF`=0, `PredTargetF`=0.
  - `MispredictE` depends only on inputs.

## Test plan
- Reset, then look up `PCF`=0x100 → `PredTakenF`=0, `PredTargetF`=0, `BranchCnt`=`MissCnt`=0.
- BEQ at `PCE`=0x100, taken, target 0x80, `PredTakenE`=0 → `MispredictE`=1, `CorrectPCE`=0x80. Next cycle `PCF`=0x100 → `PredTakenF`=1, `PredTargetF`=0x80. `MissCnt`=1.
- Same branch resolved not-taken twice → `ctr` goes 2→1→0 and `PredTakenF` goes 0 after the first. On the first, with `PredTakenE`=1: `MispredictE`=1, `CorrectPCE`=0x104. Four taken resolutions in a row saturate `ctr` at 3.
- Tag conflict: entry held by 0x100; BNE at 0x140 (same index, different tag) taken to 0x200 → entry replaced. Lookup 0x100 misses; lookup 0x140 → target 0x200.
- Non-branch (`BranchTypeE`=`NOBRANCH`) at 0x300 with `PredTakenE`=1 → `MispredictE`=1, `CorrectPCE`=0x304, no table write, `BranchCnt` unchanged.
- `ValidE`=0 with a taken BLT → no update, `MispredictE`=0. Assert `CPU_RST` in the same cycle as a taken update → all entries invalid and counters 0 next cycle.
